// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator
//   Third-order CIC decimator: turns the 1-bit PDM microphone stream into
//   signed PCM samples. The capture peripheral upstream supplies one PDM bit
//   per pdm_stb. Three integrators run at the strobe rate. Every R strobes a
//   snapshot passes through three comb stages, one stage per clock. The
//   result is shifted, saturated and placed in a valid/ready hold register.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   en           filter enable; low clears the datapath (overrun is kept)
//   pdm_stb      one-cycle strobe qualifying pdm_data
//   pdm_data     PDM bit, 1 -> +1, 0 -> -1
//   dec_ratio    decimation ratio R (0..3 behave as 4), taken once per period
//   out_shift    arithmetic right shift applied before saturation
//   pcm_data     signed PCM sample (held until overwritten)
//   pcm_valid    pcm_data holds an unread sample
//   pcm_ready    consumer takes pcm_data this cycle
//   overrun      sticky flag: an unread sample was overwritten
//   overrun_clr  clears overrun (a simultaneous new overrun wins)

module pdm_cic_decimator #(
   parameter int ACC_W = 25,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             pdm_stb,
   input  logic             pdm_data,
   input  logic [7:0]       dec_ratio,
   input  logic [4:0]       out_shift,
   output logic [OUT_W-1:0] pcm_data,
   output logic             pcm_valid,
   input  logic             pcm_ready,
   output logic             overrun,
   input  logic             overrun_clr
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_C1   = 3'd1,
      S_C2   = 3'd2,
      S_C3   = 3'd3,
      S_OUT  = 3'd4
   } state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   // Clamp a signed accumulator-width value into the signed output range.
   function automatic logic [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
      logic [OUT_W-1:0] r;
      if (v > SAT_MAX) begin
         r = SAT_MAX[OUT_W-1:0];
      end else if (v < SAT_MIN) begin
         r = SAT_MIN[OUT_W-1:0];
      end else begin
         r = v[OUT_W-1:0];
      end
      return r;
   endfunction

   state_t state_q, state_d;
   logic en_q, en_d;
   logic [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d, snap_q, snap_d;
   logic [ACC_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
   logic [ACC_W-1:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
   logic [7:0] cnt_q, cnt_d, r_q, r_d;
   logic [1:0] warm_q, warm_d;
   logic [OUT_W-1:0] pcm_data_q, pcm_data_d;
   logic pcm_valid_q, pcm_valid_d, overrun_q, overrun_d;

   logic [ACC_W-1:0] x_s;
   logic en_rise_s, wrap_s, start_s, ovr_set_s;
   logic [7:0] r_eff_s, r_cur_s;
   logic c1_en_s, c2_en_s, c3_en_s, out_en_s;
   logic signed [ACC_W-1:0] y_s;

   assign x_s       = pdm_data ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
   assign en_rise_s = en & ~en_q;
   assign r_eff_s   = (dec_ratio < 8'd4) ? 8'd4 : dec_ratio;
   // On the enable edge the latched ratio is not loaded yet, so use the live one.
   assign r_cur_s   = en_rise_s ? r_eff_s : r_q;
   assign wrap_s    = en & pdm_stb & (cnt_q == (r_cur_s - 8'd1));
   assign start_s   = wrap_s & (state_q == S_IDLE);
   assign y_s       = $signed(c3_q) >>> out_shift;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: one comb stage per cycle once a period completes.
   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  state_d = start_s ? S_C1 : S_IDLE;
            S_C1:    state_d = S_C2;
            S_C2:    state_d = S_C3;
            S_C3:    state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // FSM output decode: stage enables.
   always_comb begin
      c1_en_s  = 1'b0;
      c2_en_s  = 1'b0;
      c3_en_s  = 1'b0;
      out_en_s = 1'b0;
      case (state_q)
         S_C1:    c1_en_s  = 1'b1;
         S_C2:    c2_en_s  = 1'b1;
         S_C3:    c3_en_s  = 1'b1;
         S_OUT:   out_en_s = 1'b1;
         S_IDLE:  c1_en_s  = 1'b0;
         default: out_en_s = 1'b0;
      endcase
   end

   // Datapath next-state: integrators, period counter, combs, output holding register.
   always_comb begin
      en_d        = en;
      i1_d        = i1_q;
      i2_d        = i2_q;
      i3_d        = i3_q;
      snap_d      = snap_q;
      d1_d        = d1_q;
      d2_d        = d2_q;
      d3_d        = d3_q;
      c1_d        = c1_q;
      c2_d        = c2_q;
      c3_d        = c3_q;
      cnt_d       = cnt_q;
      r_d         = r_q;
      warm_d      = warm_q;
      pcm_data_d  = pcm_data_q;
      pcm_valid_d = pcm_valid_q;
      overrun_d   = overrun_q;
      ovr_set_s   = 1'b0;
      if (!en) begin
         i1_d        = '0;
         i2_d        = '0;
         i3_d        = '0;
         snap_d      = '0;
         d1_d        = '0;
         d2_d        = '0;
         d3_d        = '0;
         c1_d        = '0;
         c2_d        = '0;
         c3_d        = '0;
         cnt_d       = 8'd0;
         r_d         = 8'd0;
         warm_d      = 2'd0;
         pcm_data_d  = '0;
         pcm_valid_d = 1'b0;
         overrun_d   = overrun_clr ? 1'b0 : overrun_q;
      end else begin
         r_d = (en_rise_s || wrap_s) ? r_eff_s : r_q;
         // Integrators use pre-update operands; wrap modulo 2^ACC_W.
         if (pdm_stb) begin
            i1_d  = i1_q + x_s;
            i2_d  = i2_q + i1_q;
            i3_d  = i3_q + i2_q;
            cnt_d = wrap_s ? 8'd0 : (cnt_q + 8'd1);
         end else begin
            cnt_d = cnt_q;
         end
         // Snapshot is the post-update third integrator.
         if (wrap_s) begin
            snap_d = i3_q + i2_q;
         end else begin
            snap_d = snap_q;
         end
         if (c1_en_s) begin
            c1_d = snap_q - d1_q;
            d1_d = snap_q;
         end else begin
            c1_d = c1_q;
         end
         if (c2_en_s) begin
            c2_d = c1_q - d2_q;
            d2_d = c1_q;
         end else begin
            c2_d = c2_q;
         end
         if (c3_en_s) begin
            c3_d = c2_q - d3_q;
            d3_d = c2_q;
         end else begin
            c3_d = c3_q;
         end
         // First three results after a clear are transient and are dropped.
         if (out_en_s && (warm_q == 2'd3)) begin
            pcm_data_d  = sat_out(y_s);
            pcm_valid_d = 1'b1;
            ovr_set_s   = pcm_valid_q & ~pcm_ready;
         end else if (out_en_s) begin
            warm_d      = warm_q + 2'd1;
            pcm_valid_d = pcm_valid_q & ~pcm_ready;
         end else begin
            pcm_valid_d = pcm_valid_q & ~pcm_ready;
         end
         if (ovr_set_s) begin
            overrun_d = 1'b1;
         end else if (overrun_clr) begin
            overrun_d = 1'b0;
         end else begin
            overrun_d = overrun_q;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_q        <= 1'b0;
         i1_q        <= '0;
         i2_q        <= '0;
         i3_q        <= '0;
         snap_q      <= '0;
         d1_q        <= '0;
         d2_q        <= '0;
         d3_q        <= '0;
         c1_q        <= '0;
         c2_q        <= '0;
         c3_q        <= '0;
         cnt_q       <= 8'd0;
         r_q         <= 8'd0;
         warm_q      <= 2'd0;
         pcm_data_q  <= '0;
         pcm_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         en_q        <= en_d;
         i1_q        <= i1_d;
         i2_q        <= i2_d;
         i3_q        <= i3_d;
         snap_q      <= snap_d;
         d1_q        <= d1_d;
         d2_q        <= d2_d;
         d3_q        <= d3_d;
         c1_q        <= c1_d;
         c2_q        <= c2_d;
         c3_q        <= c3_d;
         cnt_q       <= cnt_d;
         r_q         <= r_d;
         warm_q      <= warm_d;
         pcm_data_q  <= pcm_data_d;
         pcm_valid_q <= pcm_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign pcm_data  = pcm_data_q;
   assign pcm_valid = pcm_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Testbench for pdm_cic_decimator: table of constant-input cases, randomized
// streams against an arithmetic CIC reference, and handshake/enable sequences.

module tb_pdm_cic_decimator;

   logic        clk = 1'b0;
   logic        rst_n, en, pdm_stb, pdm_data, pcm_ready, overrun_clr;
   logic [7:0]  dec_ratio;
   logic [4:0]  out_shift;
   logic [15:0] pcm_data;
   logic        pcm_valid, overrun;

   pdm_cic_decimator dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pdm_stb(pdm_stb), .pdm_data(pdm_data),
      .dec_ratio(dec_ratio), .out_shift(out_shift), .pcm_data(pcm_data),
      .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .overrun(overrun),
      .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int xs[$];      // +1/-1 samples since last enable
   int wraps[$];   // sample counts at which a period ended
   int got[$];     // captured PCM values
   int got_n[$];   // sample count at capture time
   int per_cnt, per_r;
   bit mon_on = 1'b0;
   int pre_data;
   logic pre_valid;

   typedef struct {
      logic [7:0] dec;
      logic [4:0] sh;
      int         pat;
      int         periods;
      int         exp_val;
   } vec_t;
   vec_t vecs[9];

   // Capture every sample taken by an always-ready consumer.
   always @(negedge clk) begin
      if (mon_on && pcm_valid && pcm_ready) begin
         got.push_back(int'($signed(pcm_data)));
         got_n.push_back(xs.size());
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int eff_r(input logic [7:0] d);
      return (d < 8'd4) ? 4 : int'(d);
   endfunction

   function automatic bit pat_bit(input int p, input int s);
      case (p)
         0:       return 1'b1;
         1:       return 1'b0;
         default: return (s % 2 == 0);
      endcase
   endfunction

   // Third integrator after n samples: sum of x_m * C(n-m, 2).
   function automatic longint i3_at(input int n);
      longint s = 0;
      for (int m = 1; m <= n; m++)
         s += longint'(xs[m-1]) * longint'((n - m) * (n - m - 1) / 2);
      return s;
   endfunction

   // k-th decimated output: third difference of i3 over period ends.
   function automatic int model_out(input int k);
      longint y = 0;
      longint c[4] = '{1, -3, 3, -1};
      for (int j = 0; j < 4; j++)
         if (k - j >= 0) y += c[j] * i3_at(wraps[k-j]);
      y = y & 64'sd33554431;
      if (y >= 64'sd16777216) y = y - 64'sd33554432;
      y = y >>> out_shift;
      if (y > 64'sd32767) y = 64'sd32767;
      else if (y < -64'sd32768) y = -64'sd32768;
      return int'(y);
   endfunction

   function automatic void model_push(input bit b);
      xs.push_back(b ? 1 : -1);
      per_cnt++;
      if (per_cnt == per_r) begin
         wraps.push_back(xs.size());
         per_cnt = 0;
         per_r = eff_r(dec_ratio);
      end
   endfunction

   task automatic restart(input logic [7:0] dr);
      @(negedge clk);
      en = 1'b0;
      dec_ratio = dr;
      repeat (2) @(negedge clk);
      en = 1'b1;
      xs.delete(); wraps.delete(); got.delete(); got_n.delete();
      per_cnt = 0;
      per_r = eff_r(dr);
      @(negedge clk);
   endtask

   // One strobe every 10 clocks; optional ready/clr pulse in the OUT cycle.
   task automatic send_ctl(input bit b, input bit rdy, input bit clr);
      @(negedge clk);
      pdm_stb = 1'b1;
      pdm_data = b;
      model_push(b);
      @(negedge clk);
      pdm_stb = 1'b0;
      repeat (3) @(negedge clk);
      pre_data = int'($signed(pcm_data));
      pre_valid = pcm_valid;
      if (rdy) pcm_ready = 1'b1;
      if (clr) overrun_clr = 1'b1;
      @(negedge clk);
      if (rdy) pcm_ready = 1'b0;
      if (clr) overrun_clr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic send(input bit b);
      send_ctl(b, 1'b0, 1'b0);
   endtask

   task automatic cmp_model(input string nm);
      int n_exp;
      n_exp = (wraps.size() > 3) ? wraps.size() - 3 : 0;
      check($sformatf("%s count", nm), got.size(), n_exp);
      for (int i = 0; i < got.size() && i < n_exp; i++) begin
         check($sformatf("%s at[%0d]", nm, i), got_n[i], wraps[i+3]);
         check($sformatf("%s val[%0d]", nm, i), got[i], model_out(i + 3));
      end
   endtask

   initial begin
      vecs[0] = '{8'd16,  5'd0, 0, 6, 4096};
      vecs[1] = '{8'd16,  5'd0, 1, 6, -4096};
      vecs[2] = '{8'd16,  5'd0, 2, 6, 0};
      vecs[3] = '{8'd255, 5'd0, 0, 5, 32767};
      vecs[4] = '{8'd255, 5'd9, 0, 5, 32385};
      vecs[5] = '{8'd2,   5'd0, 0, 8, 64};
      vecs[6] = '{8'd16,  5'd4, 1, 6, -256};
      vecs[7] = '{8'd8,   5'd0, 2, 8, 0};
      vecs[8] = '{8'd0,   5'd3, 1, 8, -8};

      rst_n = 1'b0; en = 1'b0; pdm_stb = 1'b0; pdm_data = 1'b0;
      pcm_ready = 1'b0; overrun_clr = 1'b0; dec_ratio = 8'd16; out_shift = 5'd0;
      repeat (3) @(negedge clk);
      check("reset valid", int'(pcm_valid), 0);
      check("reset data", int'(pcm_data), 0);
      check("reset overrun", int'(overrun), 0);
      rst_n = 1'b1;

      // Constant-input cases with known steady-state values.
      for (int v = 0; v < 9; v++) begin
         int nsamp;
         out_shift = vecs[v].sh;
         pcm_ready = 1'b1;
         mon_on = 1'b1;
         restart(vecs[v].dec);
         nsamp = vecs[v].periods * eff_r(vecs[v].dec);
         for (int s = 0; s < nsamp; s++) send(pat_bit(vecs[v].pat, s));
         repeat (5) @(negedge clk);
         check($sformatf("tbl%0d count", v), got.size(), vecs[v].periods - 3);
         for (int i = 0; i < got.size(); i++)
            check($sformatf("tbl%0d steady[%0d]", v, i), got[i], vecs[v].exp_val);
         cmp_model($sformatf("tbl%0d model", v));
         mon_on = 1'b0;
      end

      // Random streams with random mid-period ratio changes.
      for (int t = 0; t < 3; t++) begin
         out_shift = 5'($urandom_range(0, 6));
         pcm_ready = 1'b1;
         mon_on = 1'b1;
         restart(8'($urandom_range(4, 40)));
         for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 49) == 0) dec_ratio = 8'($urandom_range(0, 40));
            send(1'($urandom_range(0, 1)));
         end
         repeat (5) @(negedge clk);
         cmp_model($sformatf("rnd%0d", t));
         mon_on = 1'b0;
      end

      // Ratio change mid-period takes effect on the following period.
      out_shift = 5'd0;
      pcm_ready = 1'b1;
      mon_on = 1'b1;
      restart(8'd16);
      for (int s = 0; s < 40; s++) send(1'b1);
      dec_ratio = 8'd32;
      for (int s = 0; s < 72; s++) send(1'b1);
      repeat (5) @(negedge clk);
      check("ratio count", got.size(), 2);
      if (got.size() == 2) begin
         check("ratio end0", got_n[0], 80);
         check("ratio end1", got_n[1], 112);
      end
      cmp_model("ratio model");
      mon_on = 1'b0;

      // Overrun, set-wins-over-clear, ready coincident with a new sample.
      pcm_ready = 1'b0;
      restart(8'd8);
      for (int s = 0; s < 32; s++) send(1'b1);
      check("ovr first valid", int'(pcm_valid), 1);
      check("ovr first data", int'($signed(pcm_data)), model_out(3));
      check("ovr first flag", int'(overrun), 0);
      for (int s = 0; s < 8; s++) send(1'b0);
      check("ovr second valid", int'(pcm_valid), 1);
      check("ovr newest data", int'($signed(pcm_data)), model_out(4));
      check("ovr set", int'(overrun), 1);
      for (int s = 0; s < 7; s++) send(1'b0);
      send_ctl(1'b0, 1'b0, 1'b1);
      check("ovr set wins", int'(overrun), 1);
      check("ovr third data", int'($signed(pcm_data)), model_out(5));
      @(negedge clk); overrun_clr = 1'b1;
      @(negedge clk); overrun_clr = 1'b0;
      check("ovr cleared", int'(overrun), 0);
      for (int s = 0; s < 7; s++) send(1'b0);
      send_ctl(1'b0, 1'b1, 1'b0);
      check("latency old data", pre_data, model_out(5));
      check("latency old valid", int'(pre_valid), 1);
      check("rdy+new data", int'($signed(pcm_data)), model_out(6));
      check("rdy+new valid", int'(pcm_valid), 1);
      check("rdy+new no ovr", int'(overrun), 0);
      @(negedge clk); pcm_ready = 1'b1;
      @(negedge clk); pcm_ready = 1'b0;
      check("read clears valid", int'(pcm_valid), 0);
      check("read holds data", int'($signed(pcm_data)), model_out(6));

      // Enable dropped while the comb pipeline is in C2.
      restart(8'd4);
      for (int s = 0; s < 20; s++) send(1'b1);
      check("en-drop ovr pre", int'(overrun), 1);
      for (int s = 0; s < 3; s++) send(1'b1);
      @(negedge clk); pdm_stb = 1'b1; pdm_data = 1'b1;
      @(negedge clk); pdm_stb = 1'b0;
      @(negedge clk); en = 1'b0;
      @(negedge clk);
      check("en-drop valid", int'(pcm_valid), 0);
      check("en-drop data", int'(pcm_data), 0);
      check("en-drop ovr kept", int'(overrun), 1);
      repeat (6) @(negedge clk);
      check("en-drop no late out", int'(pcm_valid), 0);
      pcm_ready = 1'b1;
      mon_on = 1'b1;
      restart(8'd4);
      for (int s = 0; s < 20; s++) send(1'b1);
      repeat (5) @(negedge clk);
      check("reenable count", got.size(), 2);
      for (int i = 0; i < got.size(); i++)
         check($sformatf("reenable val[%0d]", i), got[i], 64);
      cmp_model("reenable model");
      check("reenable ovr kept", int'(overrun), 1);
      mon_on = 1'b0;

      // Reset clears the sticky flag.
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst ovr", int'(overrun), 0);
      check("rst valid", int'(pcm_valid), 0);
      check("rst data", int'(pcm_data), 0);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
